einstein_kbd_matrix: RTL and testbench
======================================

Name: einstein_kbd_matrix

Overview:
- Keyboard responder for the Einstein core: the matrix end of the PSG-port keyboard scan.
- Converts MiSTer ps2_key events into an 8x8 pressed-key matrix plus three modifier lines.
- Answers the CPU scan: the PSG drives row select on IOA and samples columns on IOB.
- Enforces a minimum key-visible time so short taps are not missed by the firmware scan.

Parameters:
- MIN_HOLD, 16'd40000, clk_sys cycles a key stays visible after its press before a release may take effect (1.25 ms at 32 MHz).
- RELQ_DEPTH, 4, number of entries in the deferred-release FIFO (power of two).

Ports:
- clk_sys  in  1  system clock, 32 MHz.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] toggle strobe, [9] 1=press, [8] E0-extended, [7:0] scancode.
- kb_row  in  8  row select from PSG IOA, active low; several rows may be low at once.
- kb_col  out  8  column return to PSG IOB, active low (0 = key down in a selected row).
- kb_shift  out  1  active low; low while LShift 0x12 or RShift 0x59 is held.
- kb_ctrl  out  1  active low; low while Ctrl 0x14 is held (E0 or not).
- kb_graph  out  1  active low; low while Alt 0x11 is held (E0 or not).
- soft_rst_req  out  1  optional-feature output; tie low when the feature is compiled out.

Behaviour:
- Clocking and reset:
  - One clock, clk_sys.
  - Reset is synchronous and active-high.
  - Reset clears the matrix, modifiers, hold counter and release FIFO, and captures ps2_key[10] into old_toggle.
  - Outputs after reset: kb_col=8'hFF, kb_shift=kb_ctrl=kb_graph=1, soft_rst_req=0.
- Event detect:
  - A new event exists when ps2_key[10] != old_toggle; old_toggle is updated in the same cycle.
  - At most one event per cycle. Events arriving during reset are discarded.
- Decode:
  - A combinational table maps {ext, code} to {hit, row[2:0], col[2:0]}; unmapped codes are ignored.
  - Mandatory entries: 0x1C -> r3c1; 0x5A -> r0c7; 0x29 -> r7c0; E0 0x75 -> r2c6.
  - Modifier codes update their modifier line and never touch the matrix.
- Press event:
  - Sets matrix[row][col].
  - Loads hold_cnt with MIN_HOLD.
  - Also removes any queued release for the same key: that entry is invalidated and skipped at drain.
- Release event:
  - If hold_cnt==0 and the FIFO is empty, clear the bit immediately.
  - Otherwise push {row,col} into the FIFO.
  - FIFO full: the oldest entry is applied at once (bit cleared), then the new entry is pushed. No release is ever lost.
- Modifier release: always immediate, not deferred.
- Hold counter:
  - Decrements to 0 and saturates there.
  - A press reload has priority over the decrement.
- Drain state machine (IDLE, WAIT, POP):
  - IDLE -> WAIT when the FIFO becomes non-empty.
  - WAIT -> POP when hold_cnt==0.
  - POP clears one bit per cycle, then returns to WAIT if the FIFO is still non-empty, else to IDLE.
  - A press arriving in POP reloads hold_cnt and forces the next state to WAIT.
- Column output, registered, 1 cycle latency from kb_row/matrix change:
  - kb_col[c] = AND over r of (kb_row[r] | ~matrix[r][c]).
  - kb_row=8'hFF gives kb_col=8'hFF.
- Modifier outputs: registered, 1 cycle after the event cycle.

Optional Feature:
- KBD_RESET_KEY_EN defined:
  - Ctrl held + Alt held + press of E0 0x71 (Del) pulses soft_rst_req high for exactly 1 cycle, 2 cycles after the event.
  - The Del key itself is not entered into the matrix.
- Not defined:
  - soft_rst_req is constant 0.
  - E0 0x71 is decoded by the table like any other code.

Test Plan:
- Reset, then kb_row=8'h00 -> kb_col=8'hFF, all modifiers 1, FIFO empty, drain FSM in IDLE.
- Press 0x1C, kb_row=8'hF7 -> kb_col=8'hFD one cycle after the matrix update; kb_row=8'hFE -> kb_col=8'hFF.
- Press then release 0x5A 100 cycles later, MIN_HOLD=1000, kb_row=8'hFE:
  - kb_col=8'h7F until cycle ~1000 after the press, then 8'hFF.
  - The release is never applied before hold_cnt reaches 0.
- Five releases queued with RELQ_DEPTH=4 while hold_cnt>0:
  - The fifth release immediately clears the oldest key.
  - The remaining four clear on consecutive cycles after hold_cnt reaches 0.
- Press 0x29 and E0 0x75, kb_row=8'h7B -> kb_col=8'hBE; repeat with the same scancode with ext=0 -> ignored, kb_col unchanged.
- Toggle-edge check:
  - Hold ps2_key stable with toggle unchanged for 50 cycles -> no state change.
  - Ctrl press -> kb_ctrl=0; Ctrl release -> kb_ctrl=1 the next cycle, even with hold_cnt>0.
  - With KBD_RESET_KEY_EN: Ctrl+Alt+E0 0x71 -> a single 1-cycle soft_rst_req pulse.

Source files
------------

// File: rtl/einstein_kbd_matrix.sv
// einstein_kbd_matrix: turns ps2_key events into the Einstein 8x8 key matrix, modifier lines and PSG column return.
// Optional Ctrl+Alt+Del soft reset request is compiled in when KBD_RESET_KEY_EN is defined.
module einstein_kbd_matrix #(
    parameter logic [15:0] MIN_HOLD   = 16'd40000,
    parameter int          RELQ_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  kb_row,
    output logic [7:0]  kb_col,
    output logic        kb_shift,
    output logic        kb_ctrl,
    output logic        kb_graph,
    output logic        soft_rst_req
);
    localparam int          QW    = (RELQ_DEPTH > 1) ? $clog2(RELQ_DEPTH) : 1;
    localparam logic [QW:0] QFULL = (QW+1)'(RELQ_DEPTH);
    localparam logic [QW:0] QZERO = {(QW+1){1'b0}};

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_POP = 2'd2} drain_state_e;

    // {hit, row[2:0], col[2:0]} for each mapped {E0, scancode}
    function automatic logic [6:0] kbd_decode(input logic ext, input logic [7:0] code);
        logic [6:0] res;
        res = 7'd0;
        case ({ext, code})
            9'h05A: res = {1'b1, 3'd0, 3'd7};
            9'h016: res = {1'b1, 3'd1, 3'd0};
            9'h01E: res = {1'b1, 3'd1, 3'd1};
            9'h026: res = {1'b1, 3'd1, 3'd2};
            9'h025: res = {1'b1, 3'd1, 3'd3};
            9'h02E: res = {1'b1, 3'd1, 3'd4};
            9'h036: res = {1'b1, 3'd1, 3'd5};
            9'h03D: res = {1'b1, 3'd1, 3'd6};
            9'h03E: res = {1'b1, 3'd1, 3'd7};
            9'h172: res = {1'b1, 3'd2, 3'd3};
            9'h174: res = {1'b1, 3'd2, 3'd4};
            9'h171: res = {1'b1, 3'd2, 3'd5};
            9'h175: res = {1'b1, 3'd2, 3'd6};
            9'h16B: res = {1'b1, 3'd2, 3'd7};
            9'h01C: res = {1'b1, 3'd3, 3'd1};
            9'h015: res = {1'b1, 3'd4, 3'd0};
            9'h01D: res = {1'b1, 3'd4, 3'd1};
            9'h024: res = {1'b1, 3'd4, 3'd2};
            9'h029: res = {1'b1, 3'd7, 3'd0};
            default: res = 7'd0;
        endcase
        return res;
    endfunction

    logic         old_toggle_r;
    logic         lshift_r, rshift_r, ctrl_r, alt_r;
    logic [7:0]   matrix_r [8];
    logic [15:0]  hold_cnt_r;
    logic [5:0]   q_key_r [RELQ_DEPTH];
    logic [RELQ_DEPTH-1:0] q_vld_r;
    logic [QW-1:0] rd_ptr_r, wr_ptr_r;
    logic [QW:0]  count_r;
    drain_state_e state_r, state_nx_s;

    logic         event_s, press_s, key_hit_s, key_press_s, key_rel_s;
    logic         rel_now_s, push_s, pop_s, pop_clr_s, hold_zero_s, q_empty_s;
    logic         lshift_nx_s, rshift_nx_s, ctrl_nx_s, alt_nx_s;
    logic [6:0]   decode_s;
    logic [5:0]   key_idx_s, head_key_s;
    logic [QW:0]  count_nx_s;
    logic [7:0]   col_s;

    // Event detect, decode, modifier next state and release-queue control
    always_comb begin
        event_s     = ps2_key[10] != old_toggle_r;
        press_s     = ps2_key[9];
        decode_s    = kbd_decode(ps2_key[8], ps2_key[7:0]);
        key_idx_s   = decode_s[5:0];
`ifdef KBD_RESET_KEY_EN
        key_hit_s   = decode_s[6] && !(ps2_key[8] && ps2_key[7:0] == 8'h71);
`else
        key_hit_s   = decode_s[6];
`endif
        key_press_s = event_s && key_hit_s && press_s;
        key_rel_s   = event_s && key_hit_s && !press_s;
        lshift_nx_s = (event_s && !ps2_key[8] && ps2_key[7:0] == 8'h12) ? press_s : lshift_r;
        rshift_nx_s = (event_s && !ps2_key[8] && ps2_key[7:0] == 8'h59) ? press_s : rshift_r;
        ctrl_nx_s   = (event_s && ps2_key[7:0] == 8'h14) ? press_s : ctrl_r;
        alt_nx_s    = (event_s && ps2_key[7:0] == 8'h11) ? press_s : alt_r;
        hold_zero_s = hold_cnt_r == 16'd0;
        q_empty_s   = count_r == QZERO;
        head_key_s  = q_key_r[rd_ptr_r];
        rel_now_s   = key_rel_s && hold_zero_s && q_empty_s;
        push_s      = key_rel_s && !rel_now_s;
        // a push into a full queue retires the oldest entry in the same cycle
        pop_s       = (push_s && count_r == QFULL) || (state_r == ST_POP && !q_empty_s);
        pop_clr_s   = pop_s && q_vld_r[rd_ptr_r];
        count_nx_s  = count_r + (QW+1)'(push_s) - (QW+1)'(pop_s);
    end

    // Drain state machine next state
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: state_nx_s = q_empty_s ? ST_IDLE : ST_WAIT;
            ST_WAIT: state_nx_s = hold_zero_s ? ST_POP : ST_WAIT;
            ST_POP: begin
                if (key_press_s) begin
                    state_nx_s = ST_WAIT;
                end else if (count_nx_s == QZERO) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    // hold_cnt is still zero, so keep draining back-to-back
                    state_nx_s = hold_zero_s ? ST_POP : ST_WAIT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Column return: a column is low when any selected row has that key down
    always_comb begin
        col_s = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                col_s[c[2:0]] = col_s[c[2:0]] & (kb_row[r[2:0]] | ~matrix_r[r[2:0]][c[2:0]]);
            end
        end
    end

    // Toggle tracking, modifier state and registered scan outputs
    always_ff @(posedge clk_sys) begin
        old_toggle_r <= ps2_key[10];
        if (reset) begin
            {lshift_r, rshift_r, ctrl_r, alt_r} <= 4'b0000;
            {kb_shift, kb_ctrl, kb_graph}       <= 3'b111;
            kb_col                               <= 8'hFF;
        end else begin
            {lshift_r, rshift_r, ctrl_r, alt_r} <= {lshift_nx_s, rshift_nx_s, ctrl_nx_s, alt_nx_s};
            kb_shift <= ~(lshift_nx_s | rshift_nx_s);
            kb_ctrl  <= ~ctrl_nx_s;
            kb_graph <= ~alt_nx_s;
            kb_col   <= col_s;
        end
    end

    // Key matrix; a press in the same cycle as a clear of the same key wins
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) matrix_r[r[2:0]] <= 8'h00;
        end else begin
            if (pop_clr_s) matrix_r[head_key_s[5:3]][head_key_s[2:0]] <= 1'b0;
            if (rel_now_s) matrix_r[key_idx_s[5:3]][key_idx_s[2:0]] <= 1'b0;
            if (key_press_s) matrix_r[key_idx_s[5:3]][key_idx_s[2:0]] <= 1'b1;
        end
    end

    // Deferred-release FIFO; a new press cancels any queued release of that key
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < RELQ_DEPTH; i++) q_key_r[i[QW-1:0]] <= 6'd0;
            q_vld_r  <= {RELQ_DEPTH{1'b0}};
            rd_ptr_r <= {QW{1'b0}};
            wr_ptr_r <= {QW{1'b0}};
            count_r  <= QZERO;
        end else begin
            for (int i = 0; i < RELQ_DEPTH; i++) begin
                if (key_press_s && q_key_r[i[QW-1:0]] == key_idx_s) q_vld_r[i[QW-1:0]] <= 1'b0;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + QW'(1);
            if (push_s) begin
                q_key_r[wr_ptr_r] <= key_idx_s;
                q_vld_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + QW'(1);
            end
            count_r <= count_nx_s;
        end
    end

    // Minimum-visible hold counter and drain state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_cnt_r <= 16'd0;
            state_r    <= ST_IDLE;
        end else begin
            if (key_press_s) hold_cnt_r <= MIN_HOLD;
            else if (!hold_zero_s) hold_cnt_r <= hold_cnt_r - 16'd1;
            state_r <= state_nx_s;
        end
    end

`ifdef KBD_RESET_KEY_EN
    logic del_fire_s, del_fire_r;

    // Ctrl+Alt+Del detect, one-cycle request two cycles after the Del event
    always_comb begin
        del_fire_s = event_s && press_s && ps2_key[8] && ps2_key[7:0] == 8'h71 && ctrl_r && alt_r;
    end

    // Soft reset request pipeline
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            del_fire_r   <= 1'b0;
            soft_rst_req <= 1'b0;
        end else begin
            del_fire_r   <= del_fire_s;
            soft_rst_req <= del_fire_r;
        end
    end
`else
    // Soft reset request is unused in this build
    always_ff @(posedge clk_sys) begin
        soft_rst_req <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Self-checking bench for einstein_kbd_matrix (MIN_HOLD=1000, RELQ_DEPTH=4); expected values flow through a scoreboard queue.
module tb_einstein_kbd_matrix;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [7:0]  kb_row;
    logic [7:0]  kb_col;
    logic        kb_shift, kb_ctrl, kb_graph, soft_rst_req;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    einstein_kbd_matrix #(.MIN_HOLD(16'd1000), .RELQ_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .kb_row(kb_row),
        .kb_col(kb_col), .kb_shift(kb_shift), .kb_ctrl(kb_ctrl), .kb_graph(kb_graph),
        .soft_rst_req(soft_rst_req)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_key(input logic press, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], press, ext, code};
        tick(1);
    endtask

    task automatic push_exp(input string n, input logic [7:0] v);
        exp_t t;
        t.name = n;
        t.val  = v;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        reset = 1'b1; kb_row = 8'h00; ps2_key = 11'd0;
        tick(2);
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        tick(1);
        reset = 1'b0;
        tick(2);
        push_exp("reset_col", 8'hFF);
        push_exp("reset_mods", 8'h07);
        push_exp("reset_softrst", 8'h00);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
        obs = {5'd0, kb_shift, kb_ctrl, kb_graph};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
        obs = {7'd0, soft_rst_req};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
    endtask

    task automatic test_press_decode();
        kb_row = 8'hF7;
        tick(1);
        push_exp("press_latency", 8'hFF);
        push_exp("press_1c_row3", 8'hFD);
        push_exp("press_1c_row0", 8'hFF);
        send_key(1'b1, 1'b0, 8'h1C);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
        tick(1);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
        kb_row = 8'hFE;
        tick(1);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
    endtask

    task automatic test_min_hold();
        int n;
        kb_row = 8'hFE;
        send_key(1'b1, 1'b0, 8'h5A);
        tick(99);
        send_key(1'b0, 1'b0, 8'h5A);
        n = 100;
        while (kb_col !== 8'hFF && n < 3000) begin
            if (n == 999) begin
                push_exp("hold_visible_n999", 8'h7F);
                e = exp_q.pop_front(); checks++;
                if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
            end
            tick(1);
            n++;
        end
        checks++;
        if (n < 1000 || n > 1010) begin
            errors++;
            $display("FAIL hold_release_time got %0d cycles want 1000..1010", n);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] codes [5];
        int w;
        codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25; codes[4] = 8'h2E;
        kb_row = 8'hFD;
        for (int i = 0; i < 5; i++) send_key(1'b1, 1'b0, codes[i]);
        for (int i = 0; i < 4; i++) send_key(1'b0, 1'b0, codes[i]);
        push_exp("queued_all_held", 8'hE0);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
        send_key(1'b0, 1'b0, codes[4]);
        tick(1);
        push_exp("overflow_oldest", 8'hE1);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
        w = 0;
        while (kb_col === 8'hE1 && w < 1500) begin
            tick(1);
            w++;
        end
        checks++;
        if (w < 990 || w > 1005) begin
            errors++;
            $display("FAIL drain_start got %0d cycles want 990..1005", w);
        end
        push_exp("drain_1", 8'hE3);
        push_exp("drain_2", 8'hE7);
        push_exp("drain_3", 8'hEF);
        push_exp("drain_4", 8'hFF);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front(); checks++;
            if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
            tick(1);
        end
    endtask

    task automatic test_ext_decode();
        kb_row = 8'h7B;
        send_key(1'b1, 1'b0, 8'h29);
        send_key(1'b1, 1'b1, 8'h75);
        tick(1);
        push_exp("ext_r7c0_r2c6", 8'hBE);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
        send_key(1'b1, 1'b1, 8'h29);
        send_key(1'b1, 1'b0, 8'h75);
        tick(2);
        push_exp("ext_mismatch_ignored", 8'hBE);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
    endtask

    task automatic test_toggle_edge();
        kb_row = 8'hFD;
        ps2_key = {ps2_key[10], 1'b1, 1'b0, 8'h16};
        for (int i = 0; i < 50; i++) begin
            tick(1);
            push_exp("no_toggle_no_event", 8'hFF);
            e = exp_q.pop_front(); checks++;
            if (kb_col !== e.val) begin errors++; $display("FAIL %s cycle %0d got %h want %h", e.name, i, kb_col, e.val); end
        end
    endtask

    task automatic test_modifiers();
        logic [7:0] obs;
        send_key(1'b1, 1'b0, 8'h14);
        push_exp("ctrl_press", 8'h05);
        obs = {5'd0, kb_shift, kb_ctrl, kb_graph};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
        send_key(1'b1, 1'b0, 8'h16);
        send_key(1'b0, 1'b0, 8'h14);
        push_exp("ctrl_release_during_hold", 8'h07);
        obs = {5'd0, kb_shift, kb_ctrl, kb_graph};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
        send_key(1'b1, 1'b0, 8'h12);
        send_key(1'b1, 1'b0, 8'h59);
        send_key(1'b0, 1'b0, 8'h12);
        push_exp("rshift_still_held", 8'h03);
        obs = {5'd0, kb_shift, kb_ctrl, kb_graph};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
        send_key(1'b0, 1'b0, 8'h59);
        send_key(1'b1, 1'b1, 8'h11);
        push_exp("shift_off_alt_e0_on", 8'h06);
        obs = {5'd0, kb_shift, kb_ctrl, kb_graph};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
        send_key(1'b0, 1'b1, 8'h11);
        send_key(1'b1, 1'b1, 8'h14);
        push_exp("ctrl_e0_on", 8'h05);
        obs = {5'd0, kb_shift, kb_ctrl, kb_graph};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
        send_key(1'b0, 1'b1, 8'h14);
    endtask

    task automatic test_del_key();
        int pulses, first;
        kb_row = 8'hFB;
        send_key(1'b1, 1'b0, 8'h14);
        send_key(1'b1, 1'b0, 8'h11);
        send_key(1'b1, 1'b1, 8'h71);
        pulses = 0; first = -1;
        for (int i = 0; i < 6; i++) begin
            if (soft_rst_req === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            tick(1);
        end
`ifdef KBD_RESET_KEY_EN
        push_exp("del_pulse_count", 8'd1);
        push_exp("del_pulse_delay", 8'd1);
        push_exp("del_not_in_matrix", 8'hBF);
`else
        push_exp("softrst_stays_low", 8'd0);
        push_exp("softrst_never_seen", 8'hFF);
        push_exp("del_decoded_r2c5", 8'h9F);
`endif
        e = exp_q.pop_front(); checks++;
        if (pulses[7:0] !== e.val) begin errors++; $display("FAIL %s got %0d want %0d", e.name, pulses, e.val); end
        e = exp_q.pop_front(); checks++;
        if (first[7:0] !== e.val) begin errors++; $display("FAIL %s got %0d want %0d", e.name, first, e.val); end
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs;
        kb_row = 8'h00;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        push_exp("midreset_col", 8'hFF);
        push_exp("midreset_mods", 8'h07);
        e = exp_q.pop_front(); checks++;
        if (kb_col !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, kb_col, e.val); end
        obs = {5'd0, kb_shift, kb_ctrl, kb_graph};
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s got %h want %h", e.name, obs, e.val); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press_decode();
        test_min_hold();
        test_fifo_overflow();
        test_ext_decode();
        test_toggle_edge();
        test_modifiers();
        test_del_key();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
